// File: rtl/store_drain_ctrl_if.sv
// store_drain_ctrl_if: single data-memory port bundle (req/ack handshake).
// master drives req/we/addr/wdata; slave returns ack and read data.
interface store_drain_ctrl_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) ();
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [DATA_LEN-1:0] mem_wdata;
    logic                mem_ack;
    logic [DATA_LEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl: drains committed stores from the store-queue head and
// shares the data-memory port with loads, bounding load priority.
// Ports: clk/reset_n; commit_store_cnt; sq_head_* in, sq_pop out;
// ld_req/ld_addr in, ld_grant/ld_rvalid/ld_rdata out; flush;
// mem (master side of store_drain_ctrl_if); pending_cnt, overflow_err.
module store_drain_ctrl #(
    parameter int ADDR_LEN     = 32,
    parameter int DATA_LEN     = 32,
    parameter int SQ_SEL       = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          commit_store_cnt,
    input  logic                sq_head_valid,
    input  logic                sq_head_addr_ready,
    input  logic [ADDR_LEN-1:0] sq_head_addr,
    input  logic [DATA_LEN-1:0] sq_head_data,
    output logic                sq_pop,
    input  logic                ld_req,
    input  logic [ADDR_LEN-1:0] ld_addr,
    output logic                ld_grant,
    output logic                ld_rvalid,
    output logic [DATA_LEN-1:0] ld_rdata,
    input  logic                flush,
    store_drain_ctrl_if.master  mem,
    output logic [SQ_SEL:0]     pending_cnt,
    output logic                overflow_err
);

    localparam int SQ_NUM = 1 << SQ_SEL;
    localparam int CW     = SQ_SEL + 2;

    localparam logic [SQ_SEL:0] PEND_FULL  = (SQ_SEL + 1)'(SQ_NUM);
    localparam logic [CW-1:0]   PEND_CAP   = CW'(SQ_NUM);
    localparam logic [2:0]      STARVE_MAX = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        STORE_WAIT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [2:0]    starve_cnt;
    logic          squash;
    logic          store_elig;
    logic          st_go;
    logic          ld_go;
    logic          st_ack;
    logic          ld_ack;
    logic [CW-1:0] pend_sum;

    always_comb begin
        state_n    = state;
        st_go      = 1'b0;
        ld_go      = 1'b0;
        st_ack     = 1'b0;
        ld_ack     = 1'b0;
        store_elig = (pending_cnt != '0) && sq_head_valid
                     && sq_head_addr_ready;

        unique case (state)
            IDLE: begin
                // Store wins when loads are idle, loads have had their
                // quota, or the queue is full of committed stores.
                if (store_elig && (!ld_req || starve_cnt == STARVE_MAX
                                   || pending_cnt == PEND_FULL)) begin
                    st_go   = 1'b1;
                    state_n = STORE_WAIT;
                end else if (ld_req && !flush) begin
                    ld_go   = 1'b1;
                    state_n = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                ld_ack = mem.mem_ack;
                if (mem.mem_ack) state_n = IDLE;
            end
            STORE_WAIT: begin
                st_ack = mem.mem_ack;
                if (mem.mem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Commits and a drain in the same cycle net out in one update.
        pend_sum = CW'(pending_cnt) + CW'(commit_store_cnt) - CW'(st_ack);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            squash        <= 1'b0;
            pending_cnt   <= '0;
            overflow_err  <= 1'b0;
            sq_pop        <= 1'b0;
            ld_grant      <= 1'b0;
            ld_rvalid     <= 1'b0;
            ld_rdata      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            state     <= state_n;
            ld_grant  <= ld_go;
            sq_pop    <= st_ack;
            ld_rvalid <= ld_ack && !(squash || flush);

            if (ld_ack) ld_rdata <= mem.mem_rdata;

            if (st_go) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= 1'b1;
                mem.mem_addr  <= sq_head_addr;
                mem.mem_wdata <= sq_head_data;
            end else if (ld_go) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= 1'b0;
                mem.mem_addr  <= ld_addr;
                mem.mem_wdata <= '0;
            end else if (st_ack || ld_ack) begin
                mem.mem_req   <= 1'b0;
            end

            // A squashed load still finishes on the bus; only its data
            // return is suppressed.
            if (ld_go) begin
                squash <= 1'b0;
            end else if (state == LOAD_WAIT && flush) begin
                squash <= 1'b1;
            end

            if (!store_elig || st_go) begin
                starve_cnt <= '0;
            end else if (ld_go && starve_cnt != 3'd7) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            if (pend_sum > PEND_CAP) begin
                pending_cnt  <= PEND_FULL;
                overflow_err <= 1'b1;
            end else begin
                pending_cnt  <= pend_sum[SQ_SEL:0];
            end
        end
    end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// tb_store_drain_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the drain/arbiter.
module tb_store_drain_ctrl;

    localparam int SQ_NUM = 8;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  commit_store_cnt;
    logic        sq_head_valid;
    logic        sq_head_addr_ready;
    logic [31:0] sq_head_addr;
    logic [31:0] sq_head_data;
    logic        sq_pop;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_grant;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        flush;
    logic [3:0]  pending_cnt;
    logic        overflow_err;

    int vectors = 0;
    int miscompares = 0;

    store_drain_ctrl_if #(.ADDR_LEN(32), .DATA_LEN(32)) mem_bus ();

    store_drain_ctrl #(
        .ADDR_LEN(32), .DATA_LEN(32), .SQ_SEL(3), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .commit_store_cnt(commit_store_cnt),
        .sq_head_valid(sq_head_valid),
        .sq_head_addr_ready(sq_head_addr_ready),
        .sq_head_addr(sq_head_addr),
        .sq_head_data(sq_head_data),
        .sq_pop(sq_pop),
        .ld_req(ld_req),
        .ld_addr(ld_addr),
        .ld_grant(ld_grant),
        .ld_rvalid(ld_rvalid),
        .ld_rdata(ld_rdata),
        .flush(flush),
        .mem(mem_bus),
        .pending_cnt(pending_cnt),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        commit_store_cnt   = 2'd0;
        sq_head_valid      = 1'b0;
        sq_head_addr_ready = 1'b0;
        sq_head_addr       = '0;
        sq_head_data       = '0;
        ld_req             = 1'b0;
        ld_addr            = '0;
        flush              = 1'b0;
        mem_bus.mem_ack    = 1'b0;
        mem_bus.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        vectors += 10;
        if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", mem_bus.mem_req); end
        if (mem_bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", mem_bus.mem_we); end
        if (mem_bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0", mem_bus.mem_addr); end
        if (mem_bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 0", mem_bus.mem_wdata); end
        if (sq_pop !== 1'b0) begin miscompares++; $display("FAIL rst_pop got %b want 0", sq_pop); end
        if (ld_grant !== 1'b0) begin miscompares++; $display("FAIL rst_grant got %b want 0", ld_grant); end
        if (ld_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b want 0", ld_rvalid); end
        if (ld_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", ld_rdata); end
        if (pending_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_pend got %0d want 0", pending_cnt); end
        if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got %b want 0", overflow_err); end
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        ld_req  = 1'b1;
        ld_addr = 32'h100;
        step();
        vectors += 4;
        if (ld_grant !== 1'b1) begin miscompares++; $display("FAIL ld_grant got %b want 1", ld_grant); end
        if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL ld_req_out got %b want 1", mem_bus.mem_req); end
        if (mem_bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL ld_we got %b want 0", mem_bus.mem_we); end
        if (mem_bus.mem_addr !== 32'h100) begin miscompares++; $display("FAIL ld_addr got %h want 100", mem_bus.mem_addr); end
        ld_req            = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hDEADBEEF;
        step();
        vectors += 4;
        if (ld_rvalid !== 1'b1) begin miscompares++; $display("FAIL ld_rvalid got %b want 1", ld_rvalid); end
        if (ld_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_rdata got %h want deadbeef", ld_rdata); end
        if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_drop got %b want 0", mem_bus.mem_req); end
        if (ld_grant !== 1'b0) begin miscompares++; $display("FAIL ld_grant_pulse got %b want 0", ld_grant); end
        mem_bus.mem_ack = 1'b0;
        step();
        vectors++;
        if (ld_rvalid !== 1'b0) begin miscompares++; $display("FAIL ld_rvalid_pulse got %b want 0", ld_rvalid); end
    endtask

    task automatic test_store();
        sq_head_valid      = 1'b1;
        sq_head_addr_ready = 1'b1;
        sq_head_addr       = 32'h40;
        sq_head_data       = 32'h1234;
        commit_store_cnt   = 2'd1;
        step();
        commit_store_cnt = 2'd0;
        vectors++;
        if (pending_cnt !== 4'd1) begin miscompares++; $display("FAIL st_pend1 got %0d want 1", pending_cnt); end
        step();
        vectors += 4;
        if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL st_req got %b want 1", mem_bus.mem_req); end
        if (mem_bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL st_we got %b want 1", mem_bus.mem_we); end
        if (mem_bus.mem_addr !== 32'h40) begin miscompares++; $display("FAIL st_addr got %h want 40", mem_bus.mem_addr); end
        if (mem_bus.mem_wdata !== 32'h1234) begin miscompares++; $display("FAIL st_wdata got %h want 1234", mem_bus.mem_wdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (mem_bus.mem_req !== 1'b1 || sq_pop !== 1'b0)
                begin miscompares++; $display("FAIL st_wait req/pop got %b/%b want 1/0", mem_bus.mem_req, sq_pop); end
        end
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        sq_head_valid   = 1'b0;
        vectors += 3;
        if (sq_pop !== 1'b1) begin miscompares++; $display("FAIL st_pop got %b want 1", sq_pop); end
        if (pending_cnt !== 4'd0) begin miscompares++; $display("FAIL st_pend0 got %0d want 0", pending_cnt); end
        if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL st_req_drop got %b want 0", mem_bus.mem_req); end
        step();
        vectors++;
        if (sq_pop !== 1'b0) begin miscompares++; $display("FAIL st_pop_pulse got %b want 0", sq_pop); end
    endtask

    task automatic test_starvation();
        int  kinds[$];
        int  at[$];
        int  pops;
        bit  prev;
        commit_store_cnt = 2'd1;
        step();
        commit_store_cnt   = 2'd0;
        ld_req             = 1'b1;
        ld_addr            = 32'h200;
        sq_head_valid      = 1'b1;
        sq_head_addr_ready = 1'b1;
        sq_head_addr       = 32'h80;
        sq_head_data       = 32'h5555;
        prev = 1'b0;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_bus.mem_req && !prev) begin
                kinds.push_back(int'(mem_bus.mem_we));
                at.push_back(c);
            end
            if (sq_pop) pops++;
            prev = mem_bus.mem_req;
            mem_bus.mem_ack = mem_bus.mem_req;
        end
        ld_req          = 1'b0;
        mem_bus.mem_ack = 1'b0;
        sq_head_valid   = 1'b0;
        step();
        vectors++;
        if (kinds.size() < 6) begin
            miscompares++;
            $display("FAIL sv_grants got %0d want >=6", kinds.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (kinds[i] != ((i == 4) ? 1 : 0))
                    begin miscompares++; $display("FAIL sv_kind[%0d] got %0d want %0d", i, kinds[i], (i == 4) ? 1 : 0); end
            end
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (at[i+1] - at[i] != 2)
                    begin miscompares++; $display("FAIL sv_gap[%0d] got %0d want 2", i, at[i+1] - at[i]); end
            end
        end
        vectors += 2;
        if (pops != 1) begin miscompares++; $display("FAIL sv_pops got %0d want 1", pops); end
        if (pending_cnt !== 4'd0) begin miscompares++; $display("FAIL sv_pend got %0d want 0", pending_cnt); end
    endtask

    task automatic test_flush();
        commit_store_cnt = 2'd1;
        step();
        commit_store_cnt = 2'd0;
        ld_req  = 1'b1;
        ld_addr = 32'h300;
        step();
        vectors++;
        if (ld_grant !== 1'b1) begin miscompares++; $display("FAIL fl_grant got %b want 1", ld_grant); end
        ld_req = 1'b0;
        flush  = 1'b1;
        step();
        flush = 1'b0;
        step();
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hCAFEF00D;
        step();
        mem_bus.mem_ack = 1'b0;
        vectors += 3;
        if (ld_rvalid !== 1'b0) begin miscompares++; $display("FAIL fl_rvalid got %b want 0", ld_rvalid); end
        if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL fl_req got %b want 0", mem_bus.mem_req); end
        if (pending_cnt !== 4'd1) begin miscompares++; $display("FAIL fl_pend got %0d want 1", pending_cnt); end
        ld_req  = 1'b1;
        ld_addr = 32'h304;
        step();
        vectors++;
        if (ld_grant !== 1'b1) begin miscompares++; $display("FAIL fl_idle_grant got %b want 1", ld_grant); end
        ld_req          = 1'b0;
        flush           = 1'b1;
        mem_bus.mem_ack = 1'b1;
        step();
        flush           = 1'b0;
        mem_bus.mem_ack = 1'b0;
        vectors++;
        if (ld_rvalid !== 1'b0) begin miscompares++; $display("FAIL fl_ack_rvalid got %b want 0", ld_rvalid); end
    endtask

    task automatic test_overflow();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        commit_store_cnt = 2'd2;
        step();
        step();
        step();
        commit_store_cnt = 2'd1;
        step();
        commit_store_cnt = 2'd0;
        vectors++;
        if (pending_cnt !== 4'd7) begin miscompares++; $display("FAIL ov_pend7 got %0d want 7", pending_cnt); end
        sq_head_valid      = 1'b1;
        sq_head_addr_ready = 1'b1;
        sq_head_addr       = 32'h44;
        sq_head_data       = 32'h99;
        step();
        sq_head_valid = 1'b0;
        vectors++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1)
            begin miscompares++; $display("FAIL ov_store req/we got %b/%b want 1/1", mem_bus.mem_req, mem_bus.mem_we); end
        mem_bus.mem_ack  = 1'b1;
        commit_store_cnt = 2'd2;
        step();
        mem_bus.mem_ack = 1'b0;
        vectors += 3;
        if (pending_cnt !== 4'd8) begin miscompares++; $display("FAIL ov_pend8 got %0d want 8", pending_cnt); end
        if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL ov_noerr got %b want 0", overflow_err); end
        if (sq_pop !== 1'b1) begin miscompares++; $display("FAIL ov_pop got %b want 1", sq_pop); end
        step();
        commit_store_cnt = 2'd0;
        vectors += 2;
        if (pending_cnt !== 4'd8) begin miscompares++; $display("FAIL ov_clamp got %0d want 8", pending_cnt); end
        if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ov_err got %b want 1", overflow_err); end
        step();
        step();
        vectors++;
        if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ov_sticky got %b want 1", overflow_err); end
    endtask

    task automatic test_reset_mid();
        sq_head_valid = 1'b1;
        sq_head_addr  = 32'h48;
        step();
        vectors++;
        if (mem_bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rm_req got %b want 1", mem_bus.mem_req); end
        reset_n = 1'b0;
        step();
        reset_n       = 1'b1;
        sq_head_valid = 1'b0;
        vectors += 3;
        if (mem_bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_drop got %b want 0", mem_bus.mem_req); end
        if (pending_cnt !== 4'd0) begin miscompares++; $display("FAIL rm_pend got %0d want 0", pending_cnt); end
        if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL rm_ovf got %b want 0", overflow_err); end
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        vectors += 2;
        if (sq_pop !== 1'b0) begin miscompares++; $display("FAIL rm_stale_pop got %b want 0", sq_pop); end
        if (pending_cnt !== 4'd0) begin miscompares++; $display("FAIL rm_stale_pend got %0d want 0", pending_cnt); end
        ld_req  = 1'b1;
        ld_addr = 32'h500;
        step();
        ld_req = 1'b0;
        vectors++;
        if (ld_grant !== 1'b1) begin miscompares++; $display("FAIL rm_idle_grant got %b want 1", ld_grant); end
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic test_random();
        int          busy;
        int          pend;
        int          starve;
        int          n;
        int          r;
        bit          sq;
        bit          ovf;
        bit          elig;
        bit          s_go;
        bit          l_go;
        bit          s_ack;
        bit          l_ack;
        bit          e_req;
        bit          e_we;
        bit          e_grant;
        bit          e_pop;
        bit          e_rv;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        reset_n = 1'b0;
        idle_inputs();
        step();
        reset_n = 1'b1;
        busy = 0; pend = 0; starve = 0; sq = 0; ovf = 0;
        e_req = 0; e_we = 0; e_grant = 0; e_pop = 0; e_rv = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 7));
            commit_store_cnt   = (r == 0) ? 2'd1 : (r == 1) ? 2'd2 : 2'd0;
            sq_head_valid      = ($urandom_range(0, 3) != 0);
            sq_head_addr_ready = ($urandom_range(0, 3) != 0);
            sq_head_addr       = $urandom;
            sq_head_data       = $urandom;
            if (!ld_req && $urandom_range(0, 2) == 0) begin
                ld_req  = 1'b1;
                ld_addr = $urandom;
            end
            flush             = ($urandom_range(0, 7) == 0);
            mem_bus.mem_ack   = ($urandom_range(0, 2) == 0);
            mem_bus.mem_rdata = $urandom;

            // busy: 0 none, 1 load outstanding, 2 store outstanding
            elig  = pend > 0 && sq_head_valid && sq_head_addr_ready;
            s_ack = busy == 2 && mem_bus.mem_ack;
            l_ack = busy == 1 && mem_bus.mem_ack;
            s_go  = busy == 0 && elig
                    && (!ld_req || starve == STARVE || pend == SQ_NUM);
            l_go  = busy == 0 && !s_go && ld_req && !flush;
            e_grant = l_go;
            e_pop   = s_ack;
            e_rv    = l_ack && !(sq || flush);
            if (l_ack) e_rdata = mem_bus.mem_rdata;
            if (busy == 1 && flush) sq = 1;
            if (s_go) begin
                busy = 2; e_req = 1; e_we = 1;
                e_addr = sq_head_addr; e_wdata = sq_head_data;
            end else if (l_go) begin
                busy = 1; e_req = 1; e_we = 0; e_addr = ld_addr; sq = 0;
            end else if (s_ack || l_ack) begin
                busy = 0; e_req = 0;
            end
            if (!elig || s_go) starve = 0;
            else if (l_go && starve < 7) starve++;
            n = pend + int'(commit_store_cnt) - (s_ack ? 1 : 0);
            if (n > SQ_NUM) begin n = SQ_NUM; ovf = 1; end
            pend = n;

            step();
            if (l_go) ld_req = 1'b0;

            vectors += 6;
            if (mem_bus.mem_req !== e_req) begin miscompares++; $display("FAIL rnd_req c=%0d got %b want %b", c, mem_bus.mem_req, e_req); end
            if (ld_grant !== e_grant) begin miscompares++; $display("FAIL rnd_grant c=%0d got %b want %b", c, ld_grant, e_grant); end
            if (sq_pop !== e_pop) begin miscompares++; $display("FAIL rnd_pop c=%0d got %b want %b", c, sq_pop, e_pop); end
            if (ld_rvalid !== e_rv) begin miscompares++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, ld_rvalid, e_rv); end
            if (pending_cnt !== 4'(pend)) begin miscompares++; $display("FAIL rnd_pend c=%0d got %0d want %0d", c, pending_cnt, pend); end
            if (overflow_err !== ovf) begin miscompares++; $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow_err, ovf); end
            if (e_req) begin
                vectors += 2;
                if (mem_bus.mem_we !== e_we) begin miscompares++; $display("FAIL rnd_we c=%0d got %b want %b", c, mem_bus.mem_we, e_we); end
                if (mem_bus.mem_addr !== e_addr) begin miscompares++; $display("FAIL rnd_addr c=%0d got %h want %h", c, mem_bus.mem_addr, e_addr); end
                if (e_we) begin
                    vectors++;
                    if (mem_bus.mem_wdata !== e_wdata) begin miscompares++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, mem_bus.mem_wdata, e_wdata); end
                end
            end
            if (e_rv) begin
                vectors++;
                if (ld_rdata !== e_rdata) begin miscompares++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, ld_rdata, e_rdata); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_load();
        test_store();
        test_starvation();
        test_flush();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_drain_ctrl.md
# store_drain_ctrl

Controller that sequences committed stores out of the store queue and shares the single data-memory port between those store drains and the load pipeline. Sits between the ROB commit stage, the store-queue head and the data memory. It counts retired-but-undrained stores and issues one memory transaction at a time through a req/ack handshake. Load priority is bounded by a starvation limit.

## Interface
- `ADDR_LEN`, 32, address width
- `DATA_LEN`, 32, data width
- `SQ_SEL`, 3, store-queue index width; `SQ_NUM` = 2**SQ_SEL
- `STARVE_LIMIT`, 4, consecutive load grants allowed while a store is eligible
- `clk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `commit_store_cnt`  in  2  stores retired by ROB this cycle (0..2)
- `sq_head_valid`  in  1  store-queue head entry valid
- `sq_head_addr_ready`  in  1  head entry address computed
- `sq_head_addr`  in  ADDR_LEN  head store address
- `sq_head_data`  in  DATA_LEN  head store data
- `sq_pop`  out  1  one-cycle pulse: head drained, advance head
- `ld_req`  in  1  load requests port (level, held until `ld_grant`)
- `ld_addr`  in  ADDR_LEN  load address
- `ld_grant`  out  1  one-cycle pulse: load accepted
- `ld_rvalid`  out  1  one-cycle pulse: load data valid
- `ld_rdata`  out  DATA_LEN  load data, registered
- `flush`  in  1  pipeline flush; squashes the in-flight load only
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`  out  1  1 = store, 0 = load
- `mem_addr`  out  ADDR_LEN  memory address
- `mem_wdata`  out  DATA_LEN  memory write data
- `mem_ack`  in  1  memory completes current request this cycle
- `mem_rdata`  in  DATA_LEN  read data, valid with `mem_ack`
- `pending_cnt`  out  SQ_SEL+1  committed stores not yet drained
- `overflow_err`  out  1  sticky: commit would exceed `SQ_NUM`

## Operation
- FSM states: IDLE, LOAD_WAIT, STORE_WAIT.
- A store is eligible when `pending_cnt>0 && sq_head_valid && sq_head_addr_ready`.
- IDLE decision, each cycle:
  - Grant the store if eligible and (`!ld_req` or `starve_cnt==STARVE_LIMIT` or `pending_cnt==SQ_NUM`). Go to STORE_WAIT.
  - Otherwise grant the load if `ld_req && !flush`. Go to LOAD_WAIT and pulse `ld_grant`.
  - Otherwise stay in IDLE.
- On entering either WAIT state:
  - Register `mem_addr`, `mem_wdata` and `mem_we`, and set `mem_req=1`.
  - All four stay stable until the cycle `mem_ack` is seen.
- `starve_cnt` (3 bits, saturating):
  - +1 on a load grant while a store is eligible.
  - Cleared on a store grant, and whenever no store is eligible.
- STORE_WAIT + `mem_ack`:
  - `mem_req` drops and `sq_pop` pulses on the next cycle.
  - `pending_cnt` decrements by 1; go to IDLE.
- LOAD_WAIT + `mem_ack`:
  - Capture `mem_rdata` into `ld_rdata`; `ld_rvalid` pulses on the next cycle unless the load is squashed.
  - Go to IDLE.
- `flush` in any LOAD_WAIT cycle, or in the ack cycle, marks the load squashed:
  - The memory transaction still completes; no `ld_rvalid`.
  - `flush` never affects `pending_cnt` or a store in flight.
- `pending_cnt` next = `pending_cnt + commit_store_cnt - (store ack ? 1 : 0)`.
  - Arithmetic is done in SQ_SEL+2 bits.
  - If the result exceeds `SQ_NUM`, clamp to `SQ_NUM` and set `overflow_err`.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; `pending_cnt=0`, `starve_cnt=0`.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `sq_pop`, `ld_grant`, `ld_rvalid`, `ld_rdata`, `overflow_err`.
- Reset asserted mid-transaction:
  - Abandons it and drops `mem_req` next edge.
  - Pending stores are lost; the store queue is reset with this block.
- Latency:
  - Decision at cycle t (IDLE) gives `mem_req` high at t+1; `ld_grant` is asserted at t+1.
  - `mem_ack` at cycle a gives `sq_pop`/`ld_rvalid` at a+1, with the FSM back in IDLE at a+1.
  - With zero-wait memory (ack at t+1), back-to-back grants occur every 2 cycles.
- Commits in the same cycle as a store ack net out in one update. Example: cnt=1, commit 2, ack → 2.
- `sq_pop` never pulses in consecutive cycles.

## Test plan
- Reset → all outputs 0, `pending_cnt=0`; `ld_req=1` at addr 0x100 → `ld_grant` and `mem_req` at t+1 with `mem_we=0`, addr 0x100. `mem_ack` with rdata 0xDEADBEEF → `ld_rvalid=1`, `ld_rdata=0xDEADBEEF` next cycle.
- `commit_store_cnt=1`, head valid/ready at addr 0x40, data 0x1234, no load → `mem_req`, `mem_we=1`, addr 0x40, wdata 0x1234. Ack after 3 wait cycles → single `sq_pop`, `pending_cnt` 1→0.
- Store eligible plus continuous `ld_req` with zero-wait memory:
  - Exactly 4 load grants occur, then a store grant.
  - `starve_cnt` clears and loads resume.
- Load in LOAD_WAIT, `flush` pulsed, ack 2 cycles later → no `ld_rvalid`; FSM back in IDLE; `pending_cnt` unchanged.
- `pending_cnt=7` (SQ_SEL=3), commit 2 in the store-ack cycle → 8, no error. Then commit 2 with no ack → clamps at 8, `overflow_err=1` sticky.
- `reset_n` low during STORE_WAIT → next edge `mem_req=0`, state IDLE, `pending_cnt=0`; the stale `mem_ack` afterward is ignored.
